// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults and read-mode encoding for the synchronous FIFO.
package fifo_pkg;

    localparam int FIFO_DATA_WIDTH    = 8;
    localparam int FIFO_POINTER_WIDTH = 4;

    typedef enum logic {
        READ_REGISTERED = 1'b0,
        READ_SHOW_AHEAD = 1'b1
    } read_mode_e;

    // Map the integer SHOW_AHEAD parameter onto the read-mode enum.
    function automatic read_mode_e read_mode(input int show_ahead);
        return (show_ahead != 0) ? READ_SHOW_AHEAD : READ_REGISTERED;
    endfunction

endpackage

// File: rtl/fifo_sync_ram.sv
// fifo_sync_ram: simple dual-port storage (1W/1R) for the synchronous FIFO.
// Offers a registered read port and a combinational read port; the parent
// decides which one drives data_out. Storage itself is never reset.
module fifo_sync_ram #(
    parameter int DATA_WIDTH    = 8,
    parameter int POINTER_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [POINTER_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic                     re,
    input  logic [POINTER_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0]    rd_data_sync,
    output logic [DATA_WIDTH-1:0]    rd_data_comb
);

    localparam int DEPTH = 1 << POINTER_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] rd_data_d;
    logic [DATA_WIDTH-1:0] rd_data_q;

    // Write port: accepted writes land in the addressed slot.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Registered read: capture the addressed word on a read, otherwise hold.
    always_comb begin
        rd_data_d = rd_data_q;
        if (re) begin
            rd_data_d = mem_q[raddr];
        end
    end

    // Registered read output clears on reset so data_out starts at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_sync = rd_data_q;
    assign rd_data_comb = mem_q[raddr];

endmodule

// File: rtl/fifo_synchronous.sv
// fifo_synchronous: single-clock FIFO with fill level, programmable
// almost-full/almost-empty thresholds and registered or show-ahead read.
// Optional sticky overflow/underflow flags are built when the macro
// FIFO_ERR_FLAG_EN is defined. POINTER_WIDTH must be at least 1.
module fifo_synchronous
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = FIFO_DATA_WIDTH,
    parameter int POINTER_WIDTH = FIFO_POINTER_WIDTH,
    parameter int SHOW_AHEAD    = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     store,
    input  logic                     load,
    input  logic [DATA_WIDTH-1:0]    data_in,
    input  logic [POINTER_WIDTH:0]   af_thresh,
    input  logic [POINTER_WIDTH:0]   ae_thresh,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic                     fifo_full,
    output logic                     fifo_empty,
    output logic                     fifo_almost_full,
    output logic                     fifo_almost_empty,
    output logic [POINTER_WIDTH:0]   fifo_level
`ifdef FIFO_ERR_FLAG_EN
    ,
    output logic                     fifo_overflow,
    output logic                     fifo_underflow
`endif
);

    localparam read_mode_e             READ_MODE  = read_mode(SHOW_AHEAD);
    localparam logic [POINTER_WIDTH:0] LEVEL_FULL = {1'b1, {POINTER_WIDTH{1'b0}}};
    localparam logic [POINTER_WIDTH:0] ONE        = {{POINTER_WIDTH{1'b0}}, 1'b1};

    logic [POINTER_WIDTH:0] w_addr_d, w_addr_q;
    logic [POINTER_WIDTH:0] r_addr_d, r_addr_q;
    logic [POINTER_WIDTH:0] level_d,  level_q;
    logic                   write_en, read_en;
    logic [DATA_WIDTH-1:0]  rd_data_sync, rd_data_comb;

    // Flags decode the registered occupancy, so they move one cycle after
    // the accepted operation and never depend on this cycle's requests.
    assign fifo_full         = (level_q == LEVEL_FULL);
    assign fifo_empty        = (level_q == '0);
    assign fifo_almost_full  = (level_q >= af_thresh);
    assign fifo_almost_empty = (level_q <= ae_thresh);
    assign fifo_level        = level_q;

    // A store while full is dropped even if a load frees a slot this cycle.
    assign write_en = store & ~fifo_full;
    assign read_en  = load  & ~fifo_empty;

    // Next-state for pointers (wrap mod 2*depth) and occupancy.
    always_comb begin
        w_addr_d = w_addr_q;
        r_addr_d = r_addr_q;
        level_d  = level_q;
        if (write_en) begin
            w_addr_d = w_addr_q + ONE;
        end
        if (read_en) begin
            r_addr_d = r_addr_q + ONE;
        end
        unique case ({write_en, read_en})
            2'b10:   level_d = level_q + ONE;
            2'b01:   level_d = level_q - ONE;
            default: level_d = level_q;
        endcase
    end

    // Pointer and level registers; reset discards all contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_addr_q <= '0;
            r_addr_q <= '0;
            level_q  <= '0;
        end else begin
            w_addr_q <= w_addr_d;
            r_addr_q <= r_addr_d;
            level_q  <= level_d;
        end
    end

    // The pointer distance must always agree with the occupancy count.
    ptr_level_consistent: assert property (
        @(posedge clk) disable iff (rst) ((w_addr_q - r_addr_q) == level_q)
    );

    fifo_sync_ram #(
        .DATA_WIDTH    (DATA_WIDTH),
        .POINTER_WIDTH (POINTER_WIDTH)
    ) u_ram (
        .clk          (clk),
        .rst          (rst),
        .we           (write_en),
        .waddr        (w_addr_q[POINTER_WIDTH-1:0]),
        .wdata        (data_in),
        .re           (read_en),
        .raddr        (r_addr_q[POINTER_WIDTH-1:0]),
        .rd_data_sync (rd_data_sync),
        .rd_data_comb (rd_data_comb)
    );

    // Show-ahead exposes the head word directly; registered mode uses the
    // word captured on the last accepted read.
    assign data_out = (READ_MODE == READ_SHOW_AHEAD) ? rd_data_comb : rd_data_sync;

`ifdef FIFO_ERR_FLAG_EN
    logic overflow_d, overflow_q;
    logic underflow_d, underflow_q;

    // Sticky error flags: the set condition is applied last so it wins.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (read_en) begin
            overflow_d = 1'b0;
        end
        if (store & fifo_full) begin
            overflow_d = 1'b1;
        end
        if (write_en) begin
            underflow_d = 1'b0;
        end
        if (load & fifo_empty) begin
            underflow_d = 1'b1;
        end
    end

    // Error flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign fifo_overflow  = overflow_q;
    assign fifo_underflow = underflow_q;
`endif

endmodule

// File: tb/tb_fifo_synchronous.sv
// tb_fifo_synchronous: drives a registered-read and a show-ahead FIFO with
// identical stimulus and checks both against a queue-based reference model.
module tb_fifo_synchronous;

    localparam int DW    = 8;
    localparam int PW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          store = 1'b0;
    logic          load = 1'b0;
    logic [DW-1:0] din = '0;
    logic [PW:0]   af = 5'd12;
    logic [PW:0]   ae = 5'd3;
    logic [PW:0]   af_n = 5'd12;
    logic [PW:0]   ae_n = 5'd3;

    logic [DW-1:0] dout_r, dout_s;
    logic          full_r, empty_r, afull_r, aempty_r;
    logic          full_s, empty_s, afull_s, aempty_s;
    logic [PW:0]   level_r, level_s;
`ifdef FIFO_ERR_FLAG_EN
    logic          ovf_r, unf_r, ovf_s, unf_s;
`endif

    always #5 clk = ~clk;

    fifo_synchronous #(.DATA_WIDTH(DW), .POINTER_WIDTH(PW), .SHOW_AHEAD(0)) dut_r (
        .clk(clk), .rst(rst), .store(store), .load(load), .data_in(din),
        .af_thresh(af), .ae_thresh(ae), .data_out(dout_r),
        .fifo_full(full_r), .fifo_empty(empty_r), .fifo_almost_full(afull_r),
        .fifo_almost_empty(aempty_r), .fifo_level(level_r)
`ifdef FIFO_ERR_FLAG_EN
        , .fifo_overflow(ovf_r), .fifo_underflow(unf_r)
`endif
    );

    fifo_synchronous #(.DATA_WIDTH(DW), .POINTER_WIDTH(PW), .SHOW_AHEAD(1)) dut_s (
        .clk(clk), .rst(rst), .store(store), .load(load), .data_in(din),
        .af_thresh(af), .ae_thresh(ae), .data_out(dout_s),
        .fifo_full(full_s), .fifo_empty(empty_s), .fifo_almost_full(afull_s),
        .fifo_almost_empty(aempty_s), .fifo_level(level_s)
`ifdef FIFO_ERR_FLAG_EN
        , .fifo_overflow(ovf_s), .fifo_underflow(unf_s)
`endif
    );

    int checks = 0;
    int errors = 0;
    int mq[$];      // reference FIFO contents, head at index 0
    int exp_q[$];   // scoreboard: words the registered DUT must present
    bit ovf_m = 1'b0;
    bit unf_m = 1'b0;
    bit mon_en = 1'b0;
    logic rd_seen = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Reference behaviour at a clock edge, from the requests of that cycle.
    task automatic model_edge();
        bit wa, ra;
        if (rst) begin
            mq.delete();
            exp_q.delete();
            ovf_m = 1'b0;
            unf_m = 1'b0;
            return;
        end
        wa = store && (mq.size() < DEPTH);
        ra = load && (mq.size() > 0);
        if (store && mq.size() == DEPTH) ovf_m = 1'b1;
        else if (ra)                     ovf_m = 1'b0;
        if (load && mq.size() == 0)      unf_m = 1'b1;
        else if (wa)                     unf_m = 1'b0;
        if (ra) exp_q.push_back(mq.pop_front());
        if (wa) mq.push_back(int'(din));
    endtask

    task automatic step(input bit s, input bit l, input logic [DW-1:0] d, input bit r = 1'b0);
        store = s;
        load  = l;
        din   = d;
        rst   = r;
        @(posedge clk);
        model_edge();
        af = af_n;
        ae = ae_n;
        @(negedge clk);
    endtask

    // Read handshake as presented by the registered DUT.
    always @(posedge clk) rd_seen <= !rst && load && !empty_r;

    // Monitor: compare outputs against the model away from the active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("level_r",  int'(level_r),  mq.size());
            chk("level_s",  int'(level_s),  mq.size());
            chk("empty_r",  int'(empty_r),  int'(mq.size() == 0));
            chk("empty_s",  int'(empty_s),  int'(mq.size() == 0));
            chk("full_r",   int'(full_r),   int'(mq.size() == DEPTH));
            chk("full_s",   int'(full_s),   int'(mq.size() == DEPTH));
            chk("afull_r",  int'(afull_r),  int'(mq.size() >= int'(af)));
            chk("afull_s",  int'(afull_s),  int'(mq.size() >= int'(af)));
            chk("aempty_r", int'(aempty_r), int'(mq.size() <= int'(ae)));
            chk("aempty_s", int'(aempty_s), int'(mq.size() <= int'(ae)));
            if (mq.size() > 0) chk("sa_head", int'(dout_s), mq[0]);
            if (rd_seen) begin
                if (exp_q.size() == 0) chk("rd_unexpected", 1, 0);
                else                   chk("rd_data", int'(dout_r), exp_q.pop_front());
            end
`ifdef FIFO_ERR_FLAG_EN
            chk("ovf_r", int'(ovf_r), int'(ovf_m));
            chk("unf_r", int'(unf_r), int'(unf_m));
            chk("ovf_s", int'(ovf_s), int'(ovf_m));
            chk("unf_s", int'(unf_s), int'(unf_m));
`endif
        end
    end

    initial begin
        int sp;
        step(0, 0, '0, 1);
        step(0, 0, '0, 1);
        mon_en = 1'b1;

        // Idle after reset.
        repeat (3) step(0, 0, '0);
        chk("rst_dout_r", int'(dout_r), 0);

        // Fill with 0x00..0x0F, then one store that must be dropped.
        for (int i = 0; i < DEPTH; i++) begin
            step(1, 0, 8'(i));
            chk("af_ramp_up", int'(afull_r), int'(i + 1 >= 12));
            chk("ae_ramp_up", int'(aempty_r), int'(i + 1 <= 3));
        end
        step(1, 0, 8'hFF);
        chk("full_drop_level", int'(level_r), DEPTH);

        // Drain in order; the monitor checks each word a cycle after load.
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 1, '0);
            chk("drain_word", int'(dout_r), i);
            chk("af_ramp_dn", int'(afull_r), int'(DEPTH - 1 - i >= 12));
        end
        step(0, 0, '0);
        chk("drained_empty", int'(empty_r), 1);

        // Hold level at 8 with concurrent store/load so pointers wrap.
        repeat (8) step(1, 0, 8'($urandom));
        repeat (20) begin
            step(1, 1, 8'($urandom));
            chk("steady_level", int'(level_r), 8);
        end
        while (mq.size() > 0) step(0, 1, '0);

        // Show-ahead: word written into an empty FIFO appears next cycle.
        step(1, 0, 8'hA5);
        chk("sa_a5", int'(dout_s), 8'hA5);
        chk("sa_nonempty", int'(empty_s), 0);
        step(0, 1, '0);
        chk("sa_empty_after", int'(empty_s), 1);
        chk("r_a5", int'(dout_r), 8'hA5);

        // Reset mid-operation at level 10 with store and load asserted.
        repeat (10) step(1, 0, 8'($urandom));
        chk("pre_rst_level", int'(level_r), 10);
        step(1, 1, 8'($urandom), 1);
        chk("rst_level", int'(level_r), 0);
        chk("rst_empty", int'(empty_r), 1);
        chk("rst_dout_mid", int'(dout_r), 0);
`ifdef FIFO_ERR_FLAG_EN
        chk("rst_ovf", int'(ovf_r), 0);
        chk("rst_unf", int'(unf_r), 0);
`endif

        // Randomized traffic with drifting fill bias, thresholds and resets.
        for (int i = 0; i < 3000; i++) begin
            sp = ((i / 150) % 2 == 0) ? 75 : 25;
            if ($urandom_range(0, 49) == 0) begin
                af_n = 5'($urandom_range(0, 20));
                ae_n = 5'($urandom_range(0, 17));
            end
            step($urandom_range(0, 99) < sp,
                 $urandom_range(0, 99) >= sp,
                 8'($urandom),
                 $urandom_range(0, 299) == 0);
        end
        while (mq.size() > 0) step(0, 1, '0);
        step(0, 0, '0);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
